// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
// Shared types and constants for the serial-MAC FIR filter.
//   - fir_state_t : controller states (IDLE, MAC, HOLD)
//   - DEF_*       : default sample, coefficient and tap-count parameters
//   - acc_width() : accumulator width that can never overflow for a given
//                   sample width, coefficient width and tap count
// ---------------------------------------------------------------------------
package fir_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_COEF_W = 8;
    localparam int DEF_TAPS   = 8;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        HOLD
    } fir_state_t;

    // Each product needs data_w+coef_w bits. Summing taps of them needs
    // clog2(taps) extra bits of headroom, so the sum can never wrap.
    function automatic int acc_width(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

endpackage

// File: rtl/mult_tc.sv
// ---------------------------------------------------------------------------
// mult_tc
// Combinational two's-complement multiplier.
// Ports:
//   a       in  a_width          signed multiplicand
//   b       in  b_width          signed multiplier
//   product out a_width+b_width  signed full-precision product
// ---------------------------------------------------------------------------
module mult_tc #(
    parameter int a_width = 8,
    parameter int b_width = 8
) (
    input  logic signed [a_width-1:0]         a,
    input  logic signed [b_width-1:0]         b,
    output logic signed [a_width+b_width-1:0] product
);

    // Both operands are signed, so the multiply is evaluated signed at the
    // full a_width+b_width result width and cannot lose any bits.
    assign product = a * b;

endmodule

// File: rtl/fir_serial_mac.sv
// ---------------------------------------------------------------------------
// fir_serial_mac
// Time-multiplexed signed FIR filter. Each accepted sample is pushed into
// the delay line, then TAPS cycles of multiply-accumulate produce
// sum(c[k]*x[k]), with x[0] the newest sample. The result is held on a
// valid/ready output until the consumer takes it.
// Ports:
//   clk        in   1       clock, all state on rising edge
//   rst        in   1       synchronous active-high reset
//   in_valid   in   1       input sample present
//   in_ready   out  1       block can accept a sample (IDLE only)
//   in_data    in   DATA_W  signed input sample
//   coef_we    in   1       coefficient write strobe (any state)
//   coef_addr  in   IDX_W   coefficient index
//   coef_data  in   COEF_W  signed coefficient
//   out_valid  out  1       filtered sample present (HOLD)
//   out_ready  in   1       consumer accepts output
//   out_data   out  ACC_W   signed filtered sample
// ---------------------------------------------------------------------------
module fir_serial_mac
    import fir_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int COEF_W = DEF_COEF_W,
    parameter  int TAPS   = DEF_TAPS,
    localparam int ACC_W  = acc_width(DATA_W, COEF_W, TAPS),
    localparam int IDX_W  = $clog2(TAPS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     coef_we,
    input  logic [IDX_W-1:0]         coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_data
);

    localparam int                PROD_W   = DATA_W + COEF_W;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(TAPS - 1);

    fir_state_t state;
    fir_state_t next_state;

    logic [IDX_W-1:0]         idx;
    logic signed [ACC_W-1:0]  acc;
    logic signed [DATA_W-1:0] x [TAPS];
    logic signed [COEF_W-1:0] c [TAPS];

    logic signed [PROD_W-1:0] product;
    logic signed [ACC_W-1:0]  product_ext;

    // One sample/coefficient pair per cycle, selected by the MAC index.
    // Registers are read here, so a coefficient write landing in the same
    // cycle only takes effect from the next cycle onward.
    mult_tc #(
        .a_width(DATA_W),
        .b_width(COEF_W)
    ) u_mult (
        .a      (x[idx]),
        .b      (c[idx]),
        .product(product)
    );

    assign product_ext = {{(ACC_W - PROD_W){product[PROD_W-1]}}, product};

    // Controller state register; reset always returns to IDLE, which also
    // discards any sample that was mid-MAC or waiting in HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake decode. The handshake outputs are also
    // gated by rst so that neither side sees a transfer while reset is held.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) begin
                    next_state = MAC;
                end
            end
            MAC: begin
                if (idx == LAST_IDX) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                out_valid = !rst;
                out_data  = rst ? '0 : acc;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: coefficient bank writes, delay-line shift on sample accept,
    // and the accumulate step. The last tap's product is added on the same
    // edge that moves the controller into HOLD, so HOLD sees the full sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
            acc <= '0;
            for (int k = 0; k < TAPS; k++) begin
                x[k] <= '0;
                c[k] <= '0;
            end
        end else begin
            if (coef_we) begin
                c[coef_addr] <= coef_data;
            end
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x[0] <= in_data;
                        for (int k = 1; k < TAPS; k++) begin
                            x[k] <= x[k-1];
                        end
                        acc <= '0;
                        idx <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + product_ext;
                    idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_serial_mac.sv
// ---------------------------------------------------------------------------
// tb_fir_serial_mac
// Directed bench for fir_serial_mac with hand-computed expected results:
// impulse response, mixed signs, extreme values, output backpressure,
// latency and reset in the middle of a MAC sequence.
// ---------------------------------------------------------------------------
module tb_fir_serial_mac;

    localparam int TAPS = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [7:0]  in_data;
    logic               coef_we;
    logic [2:0]         coef_addr;
    logic signed [7:0]  coef_data;
    logic               out_valid;
    logic               out_ready;
    logic signed [18:0] out_data;

    int vecCount = 0;
    int errCount = 0;

    fir_serial_mac dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .coef_we  (coef_we),
        .coef_addr(coef_addr),
        .coef_data(coef_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Hard stop in case some wait is never satisfied.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one rising edge and settle just past it before looking.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Single comparison point: counts the vector and reports any mismatch.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        vecCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Hold reset for two cycles and check the outputs during and after it.
    task automatic applyReset(input string tag);
        rst = 1'b1;
        tick;
        checkOutput({tag, "_rst_in_ready"}, int'(in_ready), 0);
        checkOutput({tag, "_rst_out_valid"}, int'(out_valid), 0);
        checkOutput({tag, "_rst_out_data"}, int'(out_data), 0);
        tick;
        rst = 1'b0;
        tick;
        checkOutput({tag, "_post_in_ready"}, int'(in_ready), 1);
        checkOutput({tag, "_post_out_valid"}, int'(out_valid), 0);
        checkOutput({tag, "_post_out_data"}, int'(out_data), 0);
    endtask

    task automatic writeCoef(input int addr, input int val);
        coef_we   = 1'b1;
        coef_addr = addr[2:0];
        coef_data = val[7:0];
        tick;
        coef_we   = 1'b0;
    endtask

    // Push one sample through and check flow control, latency and result.
    task automatic applyStimulus(input int sample, input int expected, input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick;
            n++;
        end
        checkOutput({tag, "_accept_ready"}, int'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = sample[7:0];
        tick;
        in_valid = 1'b0;
        checkOutput({tag, "_busy_ready"}, int'(in_ready), 0);
        n = 0;
        while (!out_valid && n < 50) begin
            tick;
            n++;
        end
        checkOutput({tag, "_latency"}, n, TAPS);
        checkOutput({tag, "_data"}, int'(out_data), expected);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        checkOutput({tag, "_ready_back"}, int'(in_ready), 1);
    endtask

    initial begin
        int n;
        int sawValid;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        out_ready = 1'b0;

        $display("[TB] reset");
        applyReset("init");

        $display("[TB] impulse response");
        for (int k = 0; k < TAPS; k++) begin
            writeCoef(k, k + 1);
        end
        for (int k = 0; k < TAPS; k++) begin
            applyStimulus((k == 0) ? 1 : 0, k + 1, $sformatf("impulse%0d", k));
        end

        $display("[TB] mixed signs");
        applyReset("mixed");
        writeCoef(0, 3);
        writeCoef(1, -2);
        applyStimulus(5, 15, "mixed0");
        applyStimulus(-7, -31, "mixed1");

        // Delay line now holds x0=-7, x1=5; sample 2 gives 3*2 + (-2)*(-7) = 20.
        $display("[TB] backpressure");
        in_valid = 1'b1;
        in_data  = 8'sd2;
        tick;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            tick;
            n++;
        end
        checkOutput("bp_latency", n, TAPS);
        checkOutput("bp_data_first", int'(out_data), 20);
        in_valid  = 1'b1;
        in_data   = 8'sd100;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            checkOutput($sformatf("bp_valid%0d", i), int'(out_valid), 1);
            checkOutput($sformatf("bp_data%0d", i), int'(out_data), 20);
            checkOutput($sformatf("bp_in_ready%0d", i), int'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        checkOutput("bp_release_valid", int'(out_valid), 0);
        checkOutput("bp_release_ready", int'(in_ready), 1);
        tick;
        checkOutput("bp_single_handshake", int'(out_valid), 0);
        // If 100 had been accepted, x1 would be 100 instead of 2.
        applyStimulus(1, -1, "bp_after");

        $display("[TB] extremes");
        applyReset("ext");
        for (int k = 0; k < TAPS; k++) begin
            writeCoef(k, -128);
        end
        for (int k = 1; k <= TAPS; k++) begin
            applyStimulus(-128, k * 16384, $sformatf("ext%0d", k));
        end

        $display("[TB] reset during MAC");
        in_valid = 1'b1;
        in_data  = 8'sd50;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        rst = 1'b1;
        tick;
        checkOutput("midrst_valid", int'(out_valid), 0);
        checkOutput("midrst_in_ready", int'(in_ready), 0);
        checkOutput("midrst_data", int'(out_data), 0);
        rst = 1'b0;
        tick;
        checkOutput("midrst_post_ready", int'(in_ready), 1);
        sawValid = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) begin
                sawValid = 1;
            end
            tick;
        end
        checkOutput("midrst_no_valid", sawValid, 0);
        applyStimulus(1, 0, "midrst_impulse");

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
